// File: rtl/note_detector_pkg.sv
// Shared constants and types for the note detector.
//   PER_W        width of the threshold constants (period counter width)
//   THR_HI       periods at or above this are below C2 (out of band, too low)
//   THR_LO       periods below this are an octave too high and get doubled
//   thr_at(k)    descending keycode boundaries, midpoints of adjacent base
//                dividers, rounded up; keycode = number of boundaries the
//                normalised period lies below
//   state_t      detector FSM states
package note_detector_pkg;

    localparam int PER_W = 18;

    localparam logic [PER_W-1:0] THR_HI = 18'd188926;
    localparam logic [PER_W-1:0] THR_LO = 18'd94463;
    localparam logic [3:0]       THR_LAST = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEAS,
        NORM,
        SEARCH,
        DONE
    } state_t;

    function automatic logic [PER_W-1:0] thr_at(input logic [3:0] k);
        case (k)
            4'd0:    return 18'd178309;
            4'd1:    return 18'd168302;
            4'd2:    return 18'd158862;
            4'd3:    return 18'd149947;
            4'd4:    return 18'd141527;
            4'd5:    return 18'd133586;
            4'd6:    return 18'd126090;
            4'd7:    return 18'd119012;
            4'd8:    return 18'd112333;
            4'd9:    return 18'd106030;
            default: return 18'd100080;
        endcase
    endfunction

endpackage

// File: rtl/note_detector_if.sv
// Signal bundle between the note detector and its user.
//   en, sig_in                 control and raw square wave into the detector
//   keycode, octave            last detected note
//   valid                      result strobe
//   out_of_range, no_signal    status flags
//   busy, state                FSM activity and raw state for observation
// Handshake: valid is a one-cycle strobe with no ready/back-pressure. On the
// cycle valid is high, keycode/octave/out_of_range carry the fresh result;
// they then hold until the next strobe or reset, so a consumer may sample
// them either on the strobe or at any later time.
interface note_detector_if;
    import note_detector_pkg::*;

    logic       en;
    logic       sig_in;
    logic [3:0] keycode;
    logic [2:0] octave;
    logic       valid;
    logic       out_of_range;
    logic       no_signal;
    logic       busy;
    state_t     state;

    modport master (
        output en, sig_in,
        input  keycode, octave, valid, out_of_range, no_signal, busy, state
    );

    modport slave (
        input  en, sig_in,
        output keycode, octave, valid, out_of_range, no_signal, busy, state
    );

endinterface

// File: rtl/note_detector_edge_sync.sv
// Synchroniser for an asynchronous input followed by a rising-edge detector.
//   clk, nrst    system clock, asynchronous active-low reset
//   sig_in       asynchronous input
//   edge_pulse   one-cycle pulse per rising edge of the synchronised input
// STAGES must be at least 2.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic sig_in,
    output logic edge_pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], sig_in};
            prev <= sync[STAGES-1];
        end
    end

    assign edge_pulse = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/note_detector.sv
// Measures the period of a square wave in clk cycles and reports the nearest
// note as keycode 0..11 plus octave 0..7.
//   clk, nrst   12 MHz clock, asynchronous active-low reset
//   bus         note_detector_if slave: en/sig_in in; keycode, octave, valid,
//               out_of_range, no_signal, busy, state out
// A period is normalised into the C2..B2 band by doubling (one octave per
// cycle), then located by a linear search over descending thresholds.
module note_detector
    import note_detector_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 18
) (
    input  logic            clk,
    input  logic            nrst,
    note_detector_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, next_state;
    logic             edge_pulse;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [2:0]       oct_w;
    logic [3:0]       key_w;
    logic [3:0]       k;
    logic             oor_w;
    logic [3:0]       keycode_r;
    logic [2:0]       octave_r;
    logic             valid_r;
    logic             oor_r;
    logic             no_signal_r;

    logic cnt_sat, per_hi, per_lo, per_below_k;

    edge_sync #(.STAGES(SYNC_STAGES)) u_edge_sync (
        .clk        (clk),
        .nrst       (nrst),
        .sig_in     (bus.sig_in),
        .edge_pulse (edge_pulse)
    );

    assign cnt_sat     = (cnt == CNT_MAX);
    assign per_hi      = (per >= CNT_W'(THR_HI));
    assign per_lo      = (per <  CNT_W'(THR_LO));
    assign per_below_k = (per <  CNT_W'(thr_at(k)));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (bus.en) next_state = ARM;
            ARM:    if (edge_pulse) next_state = MEAS;
            MEAS: begin
                // Saturation wins over a coincident edge: that period is unmeasurable.
                if (cnt_sat)         next_state = ARM;
                else if (edge_pulse) next_state = NORM;
            end
            NORM: begin
                if (per_hi || (per_lo && oct_w == 3'd7)) next_state = DONE;
                else if (!per_lo)                        next_state = SEARCH;
            end
            SEARCH: if (!per_below_k || k == THR_LAST) next_state = DONE;
            DONE:   next_state = MEAS;
            default: next_state = IDLE;
        endcase
        if (!bus.en) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            per         <= '0;
            oct_w       <= '0;
            key_w       <= '0;
            k           <= '0;
            oor_w       <= 1'b0;
            keycode_r   <= '0;
            octave_r    <= '0;
            valid_r     <= 1'b0;
            oor_r       <= 1'b0;
            no_signal_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
            if (!bus.en) begin
                cnt <= '0;
            end else begin
                // The counter runs in every enabled state so edges arriving
                // while a result is being computed still start the next period.
                if (edge_pulse)    cnt <= '0;
                else if (!cnt_sat) cnt <= cnt + CNT_W'(1);

                case (state)
                    MEAS: begin
                        if (cnt_sat) begin
                            no_signal_r <= 1'b1;
                        end else if (edge_pulse) begin
                            per   <= cnt + CNT_W'(1);
                            oct_w <= '0;
                            oor_w <= 1'b0;
                        end
                    end
                    NORM: begin
                        if (per_hi) begin
                            oor_w <= 1'b1;
                        end else if (per_lo) begin
                            if (oct_w == 3'd7) begin
                                oor_w <= 1'b1;
                            end else begin
                                // per < THR_LO here, so doubling stays in range.
                                per   <= {per[CNT_W-2:0], 1'b0};
                                oct_w <= oct_w + 3'd1;
                            end
                        end else begin
                            k     <= '0;
                            key_w <= '0;
                        end
                    end
                    SEARCH: begin
                        if (per_below_k) key_w <= key_w + 4'd1;
                        k <= k + 4'd1;
                    end
                    DONE: begin
                        valid_r     <= 1'b1;
                        no_signal_r <= 1'b0;
                        oor_r       <= oor_w;
                        if (!oor_w) begin
                            keycode_r <= key_w;
                            octave_r  <= oct_w;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.keycode      = keycode_r;
    assign bus.octave       = octave_r;
    assign bus.valid        = valid_r;
    assign bus.out_of_range = oor_r;
    assign bus.no_signal    = no_signal_r;
    assign bus.busy         = (state == NORM) || (state == SEARCH);
    assign bus.state        = state;

endmodule
